// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Round-robin arbiter that shares one Wishbone slave port between
//   N_MASTERS masters. A master raises cyc and waits for its registered
//   one-hot grant. It then runs its strobe/ack transfers and releases the
//   bus by dropping cyc. There is no preemption. Ack/err are routed back to
//   the owner only. A watchdog raises an error pulse when a strobe goes
//   unanswered for TIMEOUT cycles.
//
// Parameters
//   N_MASTERS : number of masters (2..8)
//   TIMEOUT   : unanswered-strobe cycles before a timeout error (0 = off)
//
// Ports
//   clk, rst_i                 : clock (rising edge), async active-high reset
//   m_cyc_i/m_stb_i/m_we_i     : per-master cycle, strobe, write enable
//   m_sel_i/m_adr_i/m_dat_i    : per-master select (4b), address, write data
//   m_gnt_o                    : registered one-hot grant
//   m_ack_o/m_err_o            : response routed to the owner only
//   m_dat_o                    : read data broadcast (= s_dat_i)
//   s_*_o                      : slave-side request, muxed from the owner
//   s_ack_i/s_err_i/s_dat_i    : slave response
module wb_arbiter #(
   parameter int unsigned N_MASTERS = 2,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic                      clk,
   input  logic                      rst_i,
   input  logic [N_MASTERS-1:0]      m_cyc_i,
   input  logic [N_MASTERS-1:0]      m_stb_i,
   input  logic [N_MASTERS-1:0]      m_we_i,
   input  logic [4*N_MASTERS-1:0]    m_sel_i,
   input  logic [32*N_MASTERS-1:0]   m_adr_i,
   input  logic [32*N_MASTERS-1:0]   m_dat_i,
   output logic [N_MASTERS-1:0]      m_gnt_o,
   output logic [N_MASTERS-1:0]      m_ack_o,
   output logic [N_MASTERS-1:0]      m_err_o,
   output logic [31:0]               m_dat_o,
   output logic                      s_cyc_o,
   output logic                      s_stb_o,
   output logic                      s_we_o,
   output logic [3:0]                s_sel_o,
   output logic [31:0]               s_adr_o,
   output logic [31:0]               s_dat_o,
   input  logic                      s_ack_i,
   input  logic                      s_err_i,
   input  logic [31:0]               s_dat_i
);

   localparam int unsigned IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WW-1:0] WD_MAX = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state;
   logic [IW-1:0]         owner;
   logic [IW-1:0]         last;
   logic [WW-1:0]         wd;

   logic                  busy;
   logic [N_MASTERS-1:0]  own_oh;
   logic [N_MASTERS-1:0]  req;
   logic [IW-1:0]         cand;
   logic [N_MASTERS-1:0]  cand_oh;
   logic                  cand_vld;
   logic                  tmo;

   assign busy = (state == BUSY);

   always_comb begin
      own_oh        = '0;
      own_oh[owner] = 1'b1;
   end

   // Round-robin search starting after the last owner. While BUSY the
   // current owner is masked out, so a releasing master can never win the
   // handover in its own release cycle.
   always_comb begin
      req      = busy ? (m_cyc_i & ~own_oh) : m_cyc_i;
      cand     = '0;
      cand_vld = 1'b0;
      for (int unsigned k = 1; k <= N_MASTERS; k++) begin
         int unsigned idx;
         idx = (32'(last) + k) % N_MASTERS;
         if (!cand_vld && req[IW'(idx)]) begin
            cand     = IW'(idx);
            cand_vld = 1'b1;
         end
      end
      cand_oh       = '0;
      cand_oh[cand] = 1'b1;
   end

   always_comb begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
      s_we_o  = 1'b0;
      s_sel_o = '0;
      s_adr_o = '0;
      s_dat_o = '0;
      if (busy) begin
         s_cyc_o = m_cyc_i[owner];
         s_stb_o = m_stb_i[owner];
         s_we_o  = m_we_i[owner];
         s_sel_o = m_sel_i[32'(owner)*4 +: 4];
         s_adr_o = m_adr_i[32'(owner)*32 +: 32];
         s_dat_o = m_dat_i[32'(owner)*32 +: 32];
      end
   end

   assign tmo     = (TIMEOUT != 0) && busy && s_stb_o && !s_ack_i && !s_err_i
                    && (wd == WD_MAX);
   assign m_ack_o = (busy && s_ack_i) ? own_oh : '0;
   assign m_err_o = (busy && (s_err_i || tmo)) ? own_oh : '0;
   assign m_dat_o = s_dat_i;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         owner   <= '0;
         last    <= IW'(N_MASTERS - 1);
         wd      <= '0;
         m_gnt_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               wd <= '0;
               if (cand_vld) begin
                  owner   <= cand;
                  last    <= cand;
                  m_gnt_o <= cand_oh;
                  state   <= BUSY;
               end else begin
                  m_gnt_o <= '0;
               end
            end
            BUSY: begin
               if (!m_cyc_i[owner]) begin
                  wd <= '0;
                  // Direct handover without an IDLE cycle when someone waits.
                  if (cand_vld) begin
                     owner   <= cand;
                     last    <= cand;
                     m_gnt_o <= cand_oh;
                  end else begin
                     m_gnt_o <= '0;
                     state   <= IDLE;
                  end
               end else if (TIMEOUT == 0 || s_ack_i || s_err_i || tmo) begin
                  wd <= '0;
               end else if (s_stb_o) begin
                  wd <= wd + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
